// File: rtl/x_window_sym5.sv
// 5-tap symmetric horizontal filter with per-line border padding, end-of-line flush,
// and a 3-stage arithmetic pipeline (pre-add, multiply, sum/round/saturate).
`timescale 1ns/1ps
module x_window_sym5 #(
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int H0     = 6,
    parameter int H1     = 58,
    parameter int H2     = 128,
    parameter int SHIFT  = 8,
    parameter int ROUND  = 1,
    parameter int BORDER = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          validin,
    input  logic          eolin,
    output logic          ready,
    output logic [DW-1:0] dout,
    output logic          validout,
    output logic          eolout
);
    localparam int AW = DW + CW + 3;
    localparam logic [AW-1:0] RND  = (ROUND != 0 && SHIFT > 0) ?
                                     (AW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic [AW-1:0] MAXV = (AW'(1) << DW) - AW'(1);
    localparam logic [AW-1:0] C0   = AW'(H0);
    localparam logic [AW-1:0] C1   = AW'(H1);
    localparam logic [AW-1:0] C2   = AW'(H2);

    // Handshake: a pixel is taken on a rising edge where validin and ready are both high;
    // upstream holds din/eolin stable while ready is low.
    typedef enum logic [1:0] {LSTART = 2'd0, RUN = 2'd1, FLUSH1 = 2'd2, FLUSH2 = 2'd3} state_t;
    state_t state_q, state_d;
    logic   accept, load, shift;

    always_ff @(posedge clock) begin
        if (reset) state_q <= LSTART;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSTART:  if (accept) state_d = eolin ? FLUSH1 : RUN;
            RUN:     if (accept && eolin) state_d = FLUSH1;
            FLUSH1:  state_d = FLUSH2;
            FLUSH2:  state_d = LSTART;
            default: state_d = LSTART;
        endcase
    end

    always_comb begin
        ready  = (state_q == LSTART) || (state_q == RUN);
        accept = validin && ready;
        load   = accept && (state_q == LSTART);
        shift  = accept || (state_q == FLUSH1) || (state_q == FLUSH2);
    end

    // Tags are only consumed at the centre, so only S0..S2 carry them.
    logic [DW-1:0] tap_q [5];
    logic [DW-1:0] tap_d [5];
    logic [2:0]    real_q, real_d, eol_q, eol_d;
    logic          win_v_q, win_v_d;
    logic [DW-1:0] pad_l, pad_r;

    logic [DW:0]   pa_q, pa_d, pb_q, pb_d;
    logic [DW-1:0] c_q, c_d;
    logic          v1_q, v1_d, e1_q, e1_d;

    logic [AW-1:0] m0_q, m0_d, m1_q, m1_d, m2_q, m2_d;
    logic          v2_q, v2_d, e2_q, e2_d;

    logic [AW-1:0] acc, y_full;
    logic [DW-1:0] dout_q, dout_d;
    logic          validout_q, validout_d, eolout_q, eolout_d;

    always_comb begin
        // Right-edge padding repeats S0, which holds the last real pixel or an earlier copy of it.
        pad_l = (BORDER != 0) ? din : '0;
        pad_r = (BORDER != 0) ? tap_q[0] : '0;

        tap_d[0] = tap_q[0];
        tap_d[1] = tap_q[1];
        tap_d[2] = tap_q[2];
        tap_d[3] = tap_q[3];
        tap_d[4] = tap_q[4];
        real_d   = real_q;
        eol_d    = eol_q;
        if (load) begin
            tap_d[0] = din;
            tap_d[1] = pad_l;
            tap_d[2] = pad_l;
            tap_d[3] = pad_l;
            tap_d[4] = pad_l;
            real_d   = 3'b001;
            eol_d    = {2'b00, eolin};
        end else if (shift) begin
            tap_d[4] = tap_q[3];
            tap_d[3] = tap_q[2];
            tap_d[2] = tap_q[1];
            tap_d[1] = tap_q[0];
            tap_d[0] = accept ? din : pad_r;
            real_d   = {real_q[1:0], accept};
            eol_d    = {eol_q[1:0], accept && eolin};
        end
        win_v_d = shift;

        v1_d = win_v_q && real_q[2];
        e1_d = eol_q[2];
        pa_d = {1'b0, tap_q[0]} + {1'b0, tap_q[4]};
        pb_d = {1'b0, tap_q[1]} + {1'b0, tap_q[3]};
        c_d  = tap_q[2];

        v2_d = v1_q;
        e2_d = e1_q;
        m0_d = C0 * AW'(pa_q);
        m1_d = C1 * AW'(pb_q);
        m2_d = C2 * AW'(c_q);

        acc        = m0_q + m1_q + m2_q + RND;
        y_full     = acc >> SHIFT;
        dout_d     = (y_full > MAXV) ? MAXV[DW-1:0] : y_full[DW-1:0];
        validout_d = v2_q;
        eolout_d   = v2_q && e2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) tap_q[i] <= '0;
            real_q     <= '0;
            eol_q      <= '0;
            win_v_q    <= 1'b0;
            pa_q       <= '0;
            pb_q       <= '0;
            c_q        <= '0;
            v1_q       <= 1'b0;
            e1_q       <= 1'b0;
            m0_q       <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            v2_q       <= 1'b0;
            e2_q       <= 1'b0;
            dout_q     <= '0;
            validout_q <= 1'b0;
            eolout_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) tap_q[i] <= tap_d[i];
            real_q     <= real_d;
            eol_q      <= eol_d;
            win_v_q    <= win_v_d;
            pa_q       <= pa_d;
            pb_q       <= pb_d;
            c_q        <= c_d;
            v1_q       <= v1_d;
            e1_q       <= e1_d;
            m0_q       <= m0_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            v2_q       <= v2_d;
            e2_q       <= e2_d;
            dout_q     <= dout_d;
            validout_q <= validout_d;
            eolout_q   <= eolout_d;
        end
    end

    assign dout     = dout_q;
    assign validout = validout_q;
    assign eolout   = eolout_q;
endmodule

// File: tb/tb_x_window_sym5.sv
// Bench for x_window_sym5: three parameterisations share one input stream and are
// checked against a padded-convolution reference computed per line.
`timescale 1ns/1ps
module tb_x_window_sym5;
    localparam int W = 30;

    logic       clock, reset;
    logic [7:0] din;
    logic       validin, eolin;
    logic       ready0, ready1, ready2;
    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2, e0, e1, e2;

    int checks = 0;
    int errors = 0;

    int         line_px [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];
    logic [2:0] trace_q [$];
    logic       trace_en = 1'b0;

    x_window_sym5 u_def (
        .clock(clock), .reset(reset), .din(din), .validin(validin), .eolin(eolin),
        .ready(ready0), .dout(d0), .validout(v0), .eolout(e0)
    );
    x_window_sym5 #(.BORDER(0)) u_zb (
        .clock(clock), .reset(reset), .din(din), .validin(validin), .eolin(eolin),
        .ready(ready1), .dout(d1), .validout(v1), .eolout(e1)
    );
    x_window_sym5 #(.CW(10), .H0(0), .H1(0), .H2(512)) u_sat (
        .clock(clock), .reset(reset), .din(din), .validin(validin), .eolin(eolin),
        .ready(ready2), .dout(d2), .validout(v2), .eolout(e2)
    );

    // clock/reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // monitor
    always @(negedge clock) begin
        if (v0 || v1 || v2) got_q.push_back({v0, v1, v2, e0, d0, e1, d1, e2, d2});
        if (trace_en) trace_q.push_back({ready0, ready1, ready2});
    end

    // reference model: padded 5-tap convolution of the current line
    function automatic int px(int i, int border);
        int n;
        n = line_px.size();
        if (i < 0) return (border != 0) ? line_px[0] : 0;
        if (i >= n) return (border != 0) ? line_px[n-1] : 0;
        return line_px[i];
    endfunction

    function automatic logic [7:0] ref_y(int k, int h0, int h1, int h2, int border);
        int acc;
        acc = h0 * (px(k-2, border) + px(k+2, border))
            + h1 * (px(k-1, border) + px(k+1, border))
            + h2 * px(k, border) + 128;
        acc = acc / 256;
        if (acc > 255) acc = 255;
        return 8'(acc);
    endfunction

    task automatic model_line();
        logic e;
        for (int k = 0; k < line_px.size(); k++) begin
            e = (k == line_px.size() - 1);
            exp_q.push_back({3'b111, e, ref_y(k, 6, 58, 128, 1),
                             e, ref_y(k, 6, 58, 128, 0),
                             e, ref_y(k, 0, 0, 512, 1)});
        end
    endtask

    // drivers
    task automatic drive_px(input logic [7:0] val, input logic eol, input int gap_max);
        int g, t;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        validin = 1'b0;
        eolin   = 1'b0;
        repeat (g) begin @(posedge clock); #1; end
        din = val; validin = 1'b1; eolin = eol;
        t = 0;
        while (!ready0 && t < 20) begin @(posedge clock); #1; t++; end
        if (!ready0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready=%0b required 1", ready0);
        end
        @(posedge clock); #1;
        validin = 1'b0;
        eolin   = 1'b0;
    endtask

    task automatic drive_line(input int gap_max);
        model_line();
        for (int i = 0; i < line_px.size(); i++)
            drive_px(8'(line_px[i]), i == line_px.size() - 1, gap_max);
    endtask

    task automatic drain();
        repeat (8) @(posedge clock);
        #1;
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1; validin = 1'b0; eolin = 1'b0; din = 8'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checks++;
        if ({ready0, ready1, ready2} !== 3'b111) begin
            errors++; $display("FAIL reset_ready: got %b required 111", {ready0, ready1, ready2});
        end
        checks++;
        if ({v0, v1, v2, e0, e1, e2} !== 6'b0) begin
            errors++; $display("FAIL reset_valid_eol: got %b required 000000", {v0, v1, v2, e0, e1, e2});
        end
        checks++;
        if ({d0, d1, d2} !== 24'h0) begin
            errors++; $display("FAIL reset_dout: got %h required 000000", {d0, d1, d2});
        end
    endtask

    task automatic test_constant();
        logic [W-1:0] g, x;
        logic [2:0]   tr;
        line_px.delete();
        repeat (8) line_px.push_back(100);
        trace_q.delete();
        trace_en = 1'b1;
        drive_line(0);
        repeat (2) @(negedge clock);
        #1 trace_en = 1'b0;
        checks++;
        if (trace_q.size() != 10) begin
            errors++; $display("FAIL const_ready_len: got %0d required 10", trace_q.size());
        end
        for (int i = 0; i < trace_q.size() && i < 10; i++) begin
            tr = (i < 8) ? 3'b111 : 3'b000;
            checks++;
            if (trace_q[i] !== tr) begin
                errors++; $display("FAIL const_ready[%0d]: got %b required %b", i, trace_q[i], tr);
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL const_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL const_out: got %h required %h", g, x); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_impulse();
        logic [W-1:0] g, x;
        int imp_ref [5] = '{6, 58, 128, 58, 6};
        int n;
        line_px = '{0, 0, 255, 0, 0};
        drive_line(0);
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL impulse_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL impulse_out: got %h required %h", g, x); end
            checks++;
            if (n < 5 && g[16:9] !== 8'(imp_ref[n])) begin
                errors++; $display("FAIL impulse_zero_pad[%0d]: got %0d required %0d", n, g[16:9], imp_ref[n]);
            end
            n++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_single_pixel();
        logic [W-1:0] g, x;
        line_px = '{77};
        drive_line(0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            checks++;
            if (k < 6 && v0 !== 1'b0) begin
                errors++; $display("FAIL single_early[%0d]: validout=%b required 0", k, v0);
            end else if (k == 6 && {v0, e0, d0} !== {1'b1, 1'b1, 8'd77}) begin
                errors++; $display("FAIL single_latency: got v=%b e=%b d=%0d required v=1 e=1 d=77", v0, e0, d0);
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL single_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL single_out: got %h required %h", g, x); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        logic [W-1:0] g, x;
        line_px.delete();
        repeat (6) line_px.push_back(200);
        drive_line(1);
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL sat_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL sat_out: got %h required %h", g, x); end
            checks++;
            if (g[7:0] !== 8'd255) begin errors++; $display("FAIL sat_clip: got %0d required 255", g[7:0]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] g, x;
        logic [2:0]   tr;
        int           lens [2] = '{4, 3};
        int           exp_tr [$];
        trace_q.delete();
        trace_en = 1'b1;
        for (int l = 0; l < 2; l++) begin
            line_px.delete();
            for (int i = 0; i < lens[l]; i++) line_px.push_back(int'($urandom_range(0, 255)));
            drive_line(0);
            repeat (lens[l]) exp_tr.push_back(1);
            repeat (2) exp_tr.push_back(0);
        end
        repeat (2) @(negedge clock);
        #1 trace_en = 1'b0;
        checks++;
        if (trace_q.size() != exp_tr.size()) begin
            errors++; $display("FAIL b2b_ready_len: got %0d required %0d", trace_q.size(), exp_tr.size());
        end
        for (int i = 0; i < trace_q.size() && i < exp_tr.size(); i++) begin
            tr = (exp_tr[i] != 0) ? 3'b111 : 3'b000;
            checks++;
            if (trace_q[i] !== tr) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b required %b", i, trace_q[i], tr);
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL b2b_out: got %h required %h", g, x); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_gaps();
        logic [W-1:0] g, x;
        int len;
        for (int l = 0; l < 8; l++) begin
            len = int'($urandom_range(1, 12));
            line_px.delete();
            for (int i = 0; i < len; i++) line_px.push_back(int'($urandom_range(0, 255)));
            drive_line(3);
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL rand_out: got %h required %h", g, x); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_line();
        logic [W-1:0] g, x;
        drive_px(8'($urandom_range(0, 255)), 1'b0, 0);
        drive_px(8'($urandom_range(0, 255)), 1'b0, 0);
        din = 8'($urandom_range(0, 255)); validin = 1'b1; eolin = 1'b0; reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0; validin = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL rst_stale: got %0d outputs required 0", got_q.size());
        end
        checks++;
        if (ready0 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", ready0); end
        got_q.delete();
        line_px.delete();
        repeat (5) line_px.push_back(50);
        drive_line(0);
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rst_count: got %0d required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); x = exp_q.pop_front();
            checks++;
            if (g !== x) begin errors++; $display("FAIL rst_out: got %h required %h", g, x); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_single_pixel();
        test_saturation();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
